// File: rtl/xor_parity_pkg.sv
// Shared types and helpers for the xor_parity_stream engine.
package xor_parity_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    localparam int DEF_LEN_W = 16;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/xor_parity_stream_mux_xor_reduce.sv
// Parity reduction built only from 2:1 muxes: each node selects b or ~b on a.
module mux_xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_data,
    output logic             wpar
);

    localparam int P = (WIDTH <= 1) ? 1 : (1 << $clog2(WIDTH));

    // Heap-ordered tree: leaves at [P-1 .. 2P-2], root at 0; padding leaves are 0.
    logic [2*P-2:0] node;

    always_comb begin
        node = '0;
        for (int i = 0; i < WIDTH; i++) begin
            node[P-1+i] = in_data[i];
        end
        for (int k = P - 2; k >= 0; k--) begin
            node[k] = node[2*k+1] ? ~node[2*k+2] : node[2*k+2];
        end
    end

    assign wpar = node[0];

endmodule

// File: rtl/xor_parity_stream.sv
// Streaming word/frame parity engine with a one-entry registered output stage.
// Optional in_par/out_err checking is built when XOR_PARITY_STREAM_CHECK_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no frame open; next accepted word starts one
// IN_FRAME | frame open; acc_q/len_q hold partial results
module xor_parity_stream
    import xor_parity_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ODD   = 0,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_word_par,
    output logic             out_last,
    output logic             out_frame_par,
    output logic [LEN_W-1:0] out_frame_len
`ifdef XOR_PARITY_STREAM_CHECK_EN
    ,input  logic            in_par
    ,output logic            out_err
`endif
);

    localparam logic        ODD_B   = (ODD != 0);
    localparam logic [31:0] LEN_MAX = 32'((64'd1 << LEN_W) - 64'd1);

    state_t             state_q, state_d;
    logic               acc_q, acc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               out_valid_q, out_valid_d;
    logic               out_word_par_q, out_word_par_d;
    logic               out_last_q, out_last_d;
    logic               out_frame_par_q, out_frame_par_d;
    logic [LEN_W-1:0]   out_frame_len_q, out_frame_len_d;

    logic               wpar;
    logic               accept;
    logic               acc_next;
    logic [LEN_W-1:0]   len_next;

    mux_xor_reduce #(.WIDTH(WIDTH)) u_reduce (
        .in_data (in_data),
        .wpar    (wpar)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        acc_next = (state_q == IDLE) ? wpar : (acc_q ^ wpar);
        len_next = (state_q == IDLE) ? LEN_W'(1) : LEN_W'(sat_inc(32'(len_q), LEN_MAX));
    end

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        len_d           = len_q;
        out_valid_d     = (out_valid_q && !out_ready) || accept;
        out_word_par_d  = out_word_par_q;
        out_last_d      = out_last_q;
        out_frame_par_d = out_frame_par_q;
        out_frame_len_d = out_frame_len_q;
        if (accept) begin
            out_word_par_d = wpar ^ ODD_B;
            out_last_d     = in_last;
            if (in_last) begin
                out_frame_par_d = acc_next ^ ODD_B;
                out_frame_len_d = len_next;
                acc_d           = 1'b0;
                len_d           = '0;
                state_d         = IDLE;
            end else begin
                out_frame_par_d = 1'b0;
                out_frame_len_d = '0;
                acc_d           = acc_next;
                len_d           = len_next;
                state_d         = IN_FRAME;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            acc_q           <= 1'b0;
            len_q           <= '0;
            out_valid_q     <= 1'b0;
            out_word_par_q  <= 1'b0;
            out_last_q      <= 1'b0;
            out_frame_par_q <= 1'b0;
            out_frame_len_q <= '0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            len_q           <= len_d;
            out_valid_q     <= out_valid_d;
            out_word_par_q  <= out_word_par_d;
            out_last_q      <= out_last_d;
            out_frame_par_q <= out_frame_par_d;
            out_frame_len_q <= out_frame_len_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_word_par  = out_word_par_q;
    assign out_last      = out_last_q;
    assign out_frame_par = out_frame_par_q;
    assign out_frame_len = out_frame_len_q;

`ifdef XOR_PARITY_STREAM_CHECK_EN
    logic out_err_q, out_err_d;
    logic ferr_q, ferr_d;
    logic werr, ferr_next;

    // Last word reports the sticky OR of every word error in its frame.
    always_comb begin
        werr      = ((wpar ^ ODD_B) != in_par);
        ferr_next = ((state_q == IDLE) ? 1'b0 : ferr_q) | werr;
        out_err_d = out_err_q;
        ferr_d    = ferr_q;
        if (accept) begin
            out_err_d = in_last ? ferr_next : werr;
            ferr_d    = in_last ? 1'b0 : ferr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            out_err_q <= out_err_d;
            ferr_q    <= ferr_d;
        end
    end

    assign out_err = out_err_q;
`endif

endmodule

// File: tb/tb_xor_parity_stream.sv
// Scoreboard bench: two instances (ODD=0/LEN_W=16 and ODD=1/LEN_W=2) share one stimulus stream.
module tb_xor_parity_stream;

    typedef struct {
        logic wp;
        logic last;
        logic fp;
        int   fl;
        logic err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_par = 1'b0;
    logic       out_ready = 1'b1;
    int         ready_mode = 0;

    logic        in_ready_a, out_valid_a, wp_a, last_a, fp_a;
    logic [15:0] fl_a;
    logic        in_ready_b, out_valid_b, wp_b, last_b, fp_b;
    logic [1:0]  fl_b;
    logic        err_a, err_b;

    int n_cmp = 0;
    int n_err = 0;

    exp_t qa[$];
    exp_t qb[$];
    logic [7:0] fw[$];
    logic       fpar_in[$];

    always #5 clk = ~clk;

    xor_parity_stream #(.WIDTH(8), .ODD(0), .LEN_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_word_par(wp_a), .out_last(last_a), .out_frame_par(fp_a), .out_frame_len(fl_a)
`ifdef XOR_PARITY_STREAM_CHECK_EN
        , .in_par(in_par), .out_err(err_a)
`endif
    );

    xor_parity_stream #(.WIDTH(8), .ODD(1), .LEN_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_word_par(wp_b), .out_last(last_b), .out_frame_par(fp_b), .out_frame_len(fl_b)
`ifdef XOR_PARITY_STREAM_CHECK_EN
        , .in_par(in_par), .out_err(err_b)
`endif
    );

`ifndef XOR_PARITY_STREAM_CHECK_EN
    assign err_a = 1'b0;
    assign err_b = 1'b0;
`endif

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: expectations derived from the frame's word list directly.
    function automatic exp_t model(input logic [7:0] d, input logic last, input logic p,
                                   input logic odd, input int lmax);
        exp_t e;
        logic fx, ferr;
        e.wp   = (^d) ^ odd;
        e.last = last;
        e.fp   = 1'b0;
        e.fl   = 0;
        e.err  = (e.wp != p);
        if (last) begin
            fx   = 1'b0;
            ferr = 1'b0;
            foreach (fw[i]) begin
                fx   = fx ^ (^fw[i]);
                ferr = ferr | (((^fw[i]) ^ odd) != fpar_in[i]);
            end
            e.fp  = fx ^ odd;
            e.fl  = (fw.size() > lmax) ? lmax : fw.size();
            e.err = ferr;
        end
        return e;
    endfunction

    task automatic push_word(input logic [7:0] d, input logic last, input logic p);
        fw.push_back(d);
        fpar_in.push_back(p);
        qa.push_back(model(d, last, p, 1'b0, 65535));
        qb.push_back(model(d, last, p, 1'b1, 3));
        if (last) begin
            fw.delete();
            fpar_in.delete();
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic last, input logic p);
        logic acc;
        int   waited;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_par   = p;
        waited   = 0;
        forever begin
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk);
            if (acc) begin
                push_word(d, last, p);
                break;
            end
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic mon(input int id, input logic ov, input logic ir, input logic wp,
                       input logic l, input logic fp, input int fl, input logic er);
        exp_t e;
        int   sz;
        sz = (id == 0) ? qa.size() : qb.size();
        check(id == 0 ? "a.out_valid" : "b.out_valid", int'(ov), int'(sz != 0));
        check(id == 0 ? "a.in_ready" : "b.in_ready", int'(ir), int'(sz == 0 || out_ready));
        if (ov && sz != 0) begin
            e = (id == 0) ? qa[0] : qb[0];
            check(id == 0 ? "a.word_par" : "b.word_par", int'(wp), int'(e.wp));
            check(id == 0 ? "a.last" : "b.last", int'(l), int'(e.last));
            check(id == 0 ? "a.frame_par" : "b.frame_par", int'(fp), int'(e.fp));
            check(id == 0 ? "a.frame_len" : "b.frame_len", fl, e.fl);
`ifdef XOR_PARITY_STREAM_CHECK_EN
            check(id == 0 ? "a.err" : "b.err", int'(er), int'(e.err));
`endif
            if (out_ready) begin
                if (id == 0) void'(qa.pop_front());
                else         void'(qb.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, out_valid_a, in_ready_a, wp_a, last_a, fp_a, int'(fl_a), err_a);
            mon(1, out_valid_b, in_ready_b, wp_b, last_b, fp_b, int'(fl_b), err_b);
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic check_idle_outputs();
        check("rst.a_valid", int'(out_valid_a), 0);
        check("rst.a_outs", int'({wp_a, last_a, fp_a, err_a}), 0);
        check("rst.a_len", int'(fl_a), 0);
        check("rst.a_ready", int'(in_ready_a), 1);
        check("rst.b_valid", int'(out_valid_b), 0);
        check("rst.b_outs", int'({wp_b, last_b, fp_b, err_b}), 0);
        check("rst.b_len", int'(fl_b), 0);
    endtask

    initial begin
        logic [7:0] d;
        logic       l, p;
        int         budget;

        repeat (3) @(posedge clk);
        check_idle_outputs();
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle_outputs();
        @(posedge clk);
        #1;

        // single-word frame
        drive(8'hA7, 1'b1, 1'b1);
        // back-to-back three-word frame
        drive(8'h01, 1'b0, 1'b1);
        drive(8'h03, 1'b0, 1'b0);
        drive(8'hFF, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // backpressure: sink stalls for a few cycles while words are waiting
        ready_mode = 1;
        fork
            begin
                drive(8'h11, 1'b0, 1'b0);
                drive(8'h22, 1'b0, 1'b0);
                drive(8'h37, 1'b1, 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                ready_mode = 0;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // five zero words: saturates the LEN_W=2 instance at 3
        for (int i = 0; i < 5; i++) drive(8'h00, (i == 4), 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // reset mid-frame, then a fresh single-word frame
        drive(8'h5A, 1'b0, 1'b0);
        drive(8'h0F, 1'b0, 1'b0);
        ready_mode = 1;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        fw.delete();
        fpar_in.delete();
        #3;
        check_idle_outputs();
        @(negedge clk);
        #1 rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        drive(8'h80, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // randomized traffic with random backpressure and idle gaps
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            d = 8'($urandom_range(0, 255));
            l = ($urandom_range(0, 3) == 0);
            p = (^d) ^ ($urandom_range(0, 7) == 0);
            drive(d, l, p);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drive(8'hC3, 1'b1, 1'b0);

        ready_mode = 0;
        budget = 0;
        while ((qa.size() != 0 || qb.size() != 0) && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        check("drain.a", qa.size(), 0);
        check("drain.b", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
